// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : wb_pkg
//  Brief   : Shared widths, source-select encodings and arbiter state type
//            for the register-file writeback port arbiter.
//  Rev     : 1.0  initial release
// ============================================================================
package wb_pkg;

    localparam int c_addr_w = 5;
    localparam int c_data_w = 32;
    localparam int c_cnt_w  = 4;

    localparam logic c_src_a = 1'b0;
    localparam logic c_src_b = 1'b1;

    typedef enum logic [0:0] {
        PRIO_A = 1'b0,
        PRIO_B = 1'b1
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/wb_starve_ctr.sv
`default_nettype none
// ============================================================================
//  Module  : wb_starve_ctr
//  Brief   : Saturating stall counter with clear; flags the cycle on which
//            the count lands on LIMIT.
//  Rev     : 1.0  initial release
// ============================================================================
module wb_starve_ctr
    import wb_pkg::*;
#(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_at_limit
);

    localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(LIMIT);

    logic [c_cnt_w-1:0] r_count;
    logic [c_cnt_w-1:0] w_count_nxt;

    always_comb begin
        w_count_nxt = r_count;
        if (i_clr) begin
            w_count_nxt = '0;
        end else if (i_inc && (r_count != c_limit)) begin
            w_count_nxt = r_count + c_cnt_w'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_nxt;
        end
    end

    // Looks at the next value so promotion takes effect on the following cycle.
    assign o_at_limit = (w_count_nxt == c_limit);

endmodule
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : wb_port_arbiter
//  Brief   : Arbitrates the single register-file write port between the
//            pipeline WB stage (A) and the out-of-band result return (B).
//            Optional WB_ARB_PERF_EN adds B stall / squash event counters.
//  Rev     : 1.0  initial release
// ============================================================================
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int DATA_W       = c_data_w,
    parameter int ADDR_W       = c_addr_w,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              b_squash,
`ifdef WB_ARB_PERF_EN
    output logic [31:0]       perf_b_stall,
    output logic [31:0]       perf_b_squash,
`endif
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              rf_sel
);

    arb_state_t        r_state;
    logic              r_rf_we;
    logic [ADDR_W-1:0] r_rf_waddr;
    logic [DATA_W-1:0] r_rf_wdata;
    logic              r_rf_sel;

    logic w_grant_a;
    logic w_grant_b;
    logic w_squash;
    logic w_b_stall;
    logic w_cnt_clr;
    logic w_at_limit;

    // A squash only arises when A wins, so B (older) never lands after A (newer).
    always_comb begin
        w_grant_a = 1'b0;
        w_grant_b = 1'b0;
        w_squash  = 1'b0;
        if (resetn) begin
            if ((r_state == PRIO_B) && b_valid) begin
                w_grant_b = 1'b1;
            end else if (a_valid) begin
                w_grant_a = 1'b1;
                w_squash  = (r_state == PRIO_A) && b_valid &&
                            (a_addr == b_addr) && (a_addr != '0);
            end else if (b_valid) begin
                w_grant_b = 1'b1;
            end
        end
    end

    assign a_ready   = w_grant_a;
    assign b_ready   = w_grant_b | w_squash;
    assign b_squash  = w_squash;
    assign w_b_stall = resetn && b_valid && !b_ready;
    assign w_cnt_clr = (b_valid && b_ready) || ((r_state == PRIO_B) && !b_valid);

    wb_starve_ctr #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk        (clk),
        .resetn     (resetn),
        .i_clr      (w_cnt_clr),
        .i_inc      (w_b_stall),
        .o_at_limit (w_at_limit)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= PRIO_A;
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
            r_rf_sel   <= c_src_a;
        end else begin
            case (r_state)
                PRIO_A:  if (w_at_limit) r_state <= PRIO_B;
                PRIO_B:  r_state <= PRIO_A;
                default: r_state <= PRIO_A;
            endcase

            // Register 0 is hardwired: the slot is consumed but never written.
            if (w_grant_a) begin
                r_rf_we    <= (a_addr != '0);
                r_rf_waddr <= a_addr;
                r_rf_wdata <= a_data;
                r_rf_sel   <= c_src_a;
            end else if (w_grant_b) begin
                r_rf_we    <= (b_addr != '0);
                r_rf_waddr <= b_addr;
                r_rf_wdata <= b_data;
                r_rf_sel   <= c_src_b;
            end else begin
                r_rf_we    <= 1'b0;
            end
        end
    end

    assign rf_we    = r_rf_we;
    assign rf_waddr = r_rf_waddr;
    assign rf_wdata = r_rf_wdata;
    assign rf_sel   = r_rf_sel;

`ifdef WB_ARB_PERF_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_squash;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_perf_stall  <= '0;
            r_perf_squash <= '0;
        end else begin
            r_perf_stall  <= r_perf_stall  + 32'(w_b_stall);
            r_perf_squash <= r_perf_squash + 32'(w_squash);
        end
    end

    assign perf_b_stall  = r_perf_stall;
    assign perf_b_squash = r_perf_squash;
`endif

endmodule
`default_nettype wire
